// File: rtl/glitch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | glitch_pkg: shared widths, sequencer states and constants          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package glitch_pkg;

  localparam int DEF_HOLDOFF_W = 32;
  localparam int DEF_PULSE_W   = 32;
  localparam int DEF_TMR_W     = 24;
  localparam int MIN_COOLDOWN  = 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_ARM      = 3'd2,
    S_WAIT_RDY = 3'd3,
    S_COOLDOWN = 3'd4,
    S_NEXT     = 3'd5,
    S_FINISH   = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/glitch_sweep_axis.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | glitch_sweep_axis: start/end/step counter with carry-safe exhaust  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module glitch_sweep_axis #(
  parameter int W  = 32,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic          adv_i,
  input  logic [W-1:0]  start_i,
  input  logic [W-1:0]  end_i,
  input  logic [SW-1:0] step_i,
  output logic [W-1:0]  val_o,
  output logic          exh_o
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;
  logic [W:0]   sum;

  // One extra bit catches the carry so the axis never wraps to small values.
  assign sum   = {1'b0, val_q} + {{(W + 1 - SW){1'b0}}, step_i};
  assign exh_o = (step_i == '0) || sum[W] || (sum[W-1:0] > end_i);

  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = '0;
    end else if (load_i) begin
      val_d = start_i;
    end else if (adv_i && !exh_o) begin
      val_d = sum[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule
`default_nettype wire

// File: rtl/glitch_sweep.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | glitch_sweep: 2-D (holdoff, pulse) attempt sequencer for the       |
// | glitch stage. GLITCH_SWEEP_TGT_RST_EN holds target reset low       |
// | through every cooldown.                                            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module glitch_sweep
  import glitch_pkg::*;
#(
  parameter int HOLDOFF_W = DEF_HOLDOFF_W,
  parameter int PULSE_W   = DEF_PULSE_W,
  parameter int TMR_W     = DEF_TMR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [HOLDOFF_W-1:0] holdoff_start_i,
  input  logic [HOLDOFF_W-1:0] holdoff_end_i,
  input  logic [15:0]          holdoff_step_i,
  input  logic [PULSE_W-1:0]   pulse_start_i,
  input  logic [PULSE_W-1:0]   pulse_end_i,
  input  logic [7:0]           pulse_step_i,
  input  logic [7:0]           repeat_cnt_i,
  input  logic [TMR_W-1:0]     cooldown_i,
  input  logic [TMR_W-1:0]     timeout_i,
  input  logic                 rdy_i,
  output logic                 armed_o,
  output logic [HOLDOFF_W-1:0] holdoff_o,
  output logic [PULSE_W-1:0]   pulse_o,
  output logic                 tgt_rst_n_o,
  output logic                 att_valid_o,
  output logic                 att_timeout_o,
  output logic                 busy_o,
  output logic                 done_o
);

  state_e               state_q;
  logic [HOLDOFF_W-1:0] cfg_h_start_q, cfg_h_end_q;
  logic [15:0]          cfg_h_step_q;
  logic [PULSE_W-1:0]   cfg_p_start_q, cfg_p_end_q;
  logic [7:0]           cfg_p_step_q;
  logic [7:0]           cfg_rep_q;
  logic [TMR_W-1:0]     cfg_cd_q, cfg_to_q;
  logic [7:0]           rep_q;
  logic [TMR_W-1:0]     tmr_q;
  logic                 armed_q, att_valid_q, att_to_q, busy_q, done_q;

  logic                 h_exh, p_exh;
  logic                 h_load, h_adv, p_load, p_adv, ax_clr;
  logic                 abort_hit, to_hit, cd_done, enter_cool, stay_cool;
  logic [TMR_W-1:0]     tmr_inc, cd_eff;
  logic [7:0]           rep_eff;

  assign abort_hit  = abort_i && (state_q != S_IDLE);
  assign tmr_inc    = tmr_q + TMR_W'(1);
  assign cd_eff     = (cfg_cd_q == '0) ? TMR_W'(MIN_COOLDOWN) : cfg_cd_q;
  assign rep_eff    = (cfg_rep_q == 8'd0) ? 8'd1 : cfg_rep_q;
  assign to_hit     = (cfg_to_q != '0) && (tmr_inc == cfg_to_q);
  assign cd_done    = (tmr_inc >= cd_eff);
  assign enter_cool = !abort_hit && (state_q == S_WAIT_RDY) && (rdy_i || to_hit);
  assign stay_cool  = !abort_hit && (state_q == S_COOLDOWN) && !cd_done;

  // Axis strobes: inner axis advances first, outer only once inner wraps.
  always_comb begin
    h_load = 1'b0;
    h_adv  = 1'b0;
    p_load = 1'b0;
    p_adv  = 1'b0;
    ax_clr = 1'b0;
    if (abort_hit) begin
      ax_clr = 1'b1;
    end else begin
      case (state_q)
        S_LOAD: begin
          h_load = 1'b1;
          p_load = 1'b1;
        end
        S_NEXT: begin
          if (rep_q <= 8'd1) begin
            if (!p_exh) begin
              p_adv = 1'b1;
            end else if (!h_exh) begin
              p_load = 1'b1;
              h_adv  = 1'b1;
            end
          end
        end
        S_FINISH: ax_clr = 1'b1;
        default: ;
      endcase
    end
  end

  glitch_sweep_axis #(.W(HOLDOFF_W), .SW(16)) u_holdoff_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (ax_clr),
    .load_i  (h_load),
    .adv_i   (h_adv),
    .start_i (cfg_h_start_q),
    .end_i   (cfg_h_end_q),
    .step_i  (cfg_h_step_q),
    .val_o   (holdoff_o),
    .exh_o   (h_exh)
  );

  glitch_sweep_axis #(.W(PULSE_W), .SW(8)) u_pulse_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (ax_clr),
    .load_i  (p_load),
    .adv_i   (p_adv),
    .start_i (cfg_p_start_q),
    .end_i   (cfg_p_end_q),
    .step_i  (cfg_p_step_q),
    .val_o   (pulse_o),
    .exh_o   (p_exh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cfg_h_start_q <= '0;
      cfg_h_end_q   <= '0;
      cfg_h_step_q  <= '0;
      cfg_p_start_q <= '0;
      cfg_p_end_q   <= '0;
      cfg_p_step_q  <= '0;
      cfg_rep_q     <= '0;
      cfg_cd_q      <= '0;
      cfg_to_q      <= '0;
      rep_q         <= '0;
      tmr_q         <= '0;
      armed_q       <= 1'b0;
      att_valid_q   <= 1'b0;
      att_to_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      att_valid_q <= 1'b0;
      att_to_q    <= 1'b0;
      done_q      <= 1'b0;
      if (abort_hit) begin
        state_q <= S_IDLE;
        armed_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              cfg_h_start_q <= holdoff_start_i;
              cfg_h_end_q   <= holdoff_end_i;
              cfg_h_step_q  <= holdoff_step_i;
              cfg_p_start_q <= pulse_start_i;
              cfg_p_end_q   <= pulse_end_i;
              cfg_p_step_q  <= pulse_step_i;
              cfg_rep_q     <= repeat_cnt_i;
              cfg_cd_q      <= cooldown_i;
              cfg_to_q      <= timeout_i;
              busy_q        <= 1'b1;
              state_q       <= S_LOAD;
            end
          end
          S_LOAD: begin
            rep_q   <= rep_eff;
            state_q <= S_ARM;
          end
          S_ARM: begin
            armed_q <= 1'b1;
            tmr_q   <= '0;
            state_q <= S_WAIT_RDY;
          end
          S_WAIT_RDY: begin
            if (enter_cool) begin
              armed_q     <= 1'b0;
              att_valid_q <= 1'b1;
              att_to_q    <= !rdy_i;
              tmr_q       <= '0;
              state_q     <= S_COOLDOWN;
            end else begin
              tmr_q <= tmr_inc;
            end
          end
          S_COOLDOWN: begin
            if (stay_cool) begin
              tmr_q <= tmr_inc;
            end else begin
              state_q <= S_NEXT;
            end
          end
          S_NEXT: begin
            if (rep_q > 8'd1) begin
              rep_q   <= rep_q - 8'd1;
              state_q <= S_ARM;
            end else if (!p_exh || !h_exh) begin
              rep_q   <= rep_eff;
              state_q <= S_ARM;
            end else begin
              state_q <= S_FINISH;
            end
          end
          S_FINISH: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef GLITCH_SWEEP_TGT_RST_EN
  logic tgt_rst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_rst_q <= 1'b1;
    end else begin
      tgt_rst_q <= !(enter_cool || stay_cool);
    end
  end

  assign tgt_rst_n_o = tgt_rst_q;
`else
  logic unused_cool;
  assign unused_cool = enter_cool ^ stay_cool;
  assign tgt_rst_n_o = 1'b1 | unused_cool;
`endif

  assign armed_o       = armed_q;
  assign att_valid_o   = att_valid_q;
  assign att_timeout_o = att_to_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_glitch_sweep.sv
`default_nettype none
// Self-checking bench for glitch_sweep: hand-derived table, randomized sweeps
// against a point-list model, plus abort and mid-sweep reset sequences.
module tb_glitch_sweep;

  logic        clk, rst_n, start_i, abort_i, rdy_i;
  logic [31:0] hs_i, he_i, ps_i, pe_i;
  logic [15:0] hst_i;
  logic [7:0]  pst_i, rep_i;
  logic [23:0] cd_i, tmo_i;
  logic        armed_o, tgt_rst_n_o, att_valid_o, att_timeout_o, busy_o, done_o;
  logic [31:0] holdoff_o, pulse_o;

  int n_vec = 0;
  int n_miss = 0;
  int rdy_dly_g = 0;

  typedef struct {
    logic [31:0] hs, he;
    logic [15:0] hst;
    logic [31:0] ps, pe;
    logic [7:0]  pst;
    logic [7:0]  rep;
    logic [23:0] cd, tmo;
    int          rdy;
    int          exp_att;
    logic        exp_to;
  } vec_t;

  typedef struct {
    longint h;
    longint p;
  } att_t;

  glitch_sweep dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .holdoff_start_i (hs_i),
    .holdoff_end_i   (he_i),
    .holdoff_step_i  (hst_i),
    .pulse_start_i   (ps_i),
    .pulse_end_i     (pe_i),
    .pulse_step_i    (pst_i),
    .repeat_cnt_i    (rep_i),
    .cooldown_i      (cd_i),
    .timeout_i       (tmo_i),
    .rdy_i           (rdy_i),
    .armed_o         (armed_o),
    .holdoff_o       (holdoff_o),
    .pulse_o         (pulse_o),
    .tgt_rst_n_o     (tgt_rst_n_o),
    .att_valid_o     (att_valid_o),
    .att_timeout_o   (att_timeout_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Glitch-stage stand-in: rdy is sampled on the rdy_dly-th edge after armed rises.
  initial begin
    int acnt;
    acnt  = 0;
    rdy_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!armed_o) begin
        acnt  = 0;
        rdy_i = 1'b0;
      end else begin
        acnt++;
        rdy_i = (rdy_dly_g != 0) && (acnt == rdy_dly_g);
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint nxt(input longint v, input longint st, input longint e);
    longint n;
    if (st == 0) return -1;
    n = v + st;
    if (n > e || n >= (longint'(1) << 32)) return -1;
    return n;
  endfunction

  task automatic drive_cfg(input vec_t v);
    hs_i = v.hs;  he_i = v.he;  hst_i = v.hst;
    ps_i = v.ps;  pe_i = v.pe;  pst_i = v.pst;
    rep_i = v.rep; cd_i = v.cd; tmo_i = v.tmo;
    rdy_dly_g = v.rdy;
  endtask

  task automatic scramble_cfg();
    hs_i = $urandom; he_i = $urandom; hst_i = 16'($urandom);
    ps_i = $urandom; pe_i = $urandom; pst_i = 8'($urandom);
    rep_i = 8'($urandom); cd_i = 24'($urandom); tmo_i = 24'($urandom);
  endtask

  task automatic run_sweep(input vec_t v, input string tag);
    att_t   exp_q[$];
    int     rep_n, exp_n, exp_hi, exp_gap, cd_eff, exp_tgt;
    int     edge_n, n_att, n_done, lo_cnt, hi_cnt, tgt_lo;
    logic   prev_armed;
    bit     fin;
    rep_n  = (v.rep == 0) ? 1 : int'(v.rep);
    for (longint h = longint'(v.hs); h >= 0; h = nxt(h, longint'(v.hst), longint'(v.he)))
      for (longint p = longint'(v.ps); p >= 0; p = nxt(p, longint'(v.pst), longint'(v.pe)))
        for (int r = 0; r < rep_n; r++) exp_q.push_back('{h, p});
    exp_n   = (v.exp_att >= 0) ? v.exp_att : exp_q.size();
    exp_hi  = v.exp_to ? int'(v.tmo) : v.rdy;
    cd_eff  = (v.cd == 0) ? 1 : int'(v.cd);
    exp_gap = cd_eff + 2;  // cooldown, then one cycle each in NEXT and ARM
`ifdef GLITCH_SWEEP_TGT_RST_EN
    exp_tgt = exp_n * cd_eff;
`else
    exp_tgt = 0;
`endif
    @(negedge clk);
    drive_cfg(v);
    start_i = 1'b1;
    @(posedge clk);
    edge_n = 0; n_att = 0; n_done = 0; lo_cnt = 0; hi_cnt = 0; tgt_lo = 0;
    prev_armed = 1'b0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      #1;
      scramble_cfg();
      if (armed_o && !prev_armed) begin
        if (n_att == 0) check({tag, "_arm_latency"}, edge_n, 2);
        else check({tag, "_armed_low_gap"}, lo_cnt, exp_gap);
        hi_cnt = 0;
      end
      if (armed_o) hi_cnt++;
      if (att_valid_o) lo_cnt = 1;
      else if (!armed_o) lo_cnt++;
      if (!tgt_rst_n_o) tgt_lo++;
      if (att_valid_o) begin
        if (n_att < exp_q.size()) begin
          check({tag, "_holdoff"}, holdoff_o, exp_q[n_att].h);
          check({tag, "_pulse"}, pulse_o, exp_q[n_att].p);
          check({tag, "_att_timeout"}, att_timeout_o, v.exp_to);
          check({tag, "_armed_cycles"}, hi_cnt, exp_hi);
        end else begin
          check({tag, "_extra_attempt"}, n_att + 1, exp_q.size());
        end
        n_att++;
      end
      if (done_o) begin
        n_done++;
        check({tag, "_busy_at_done"}, busy_o, 0);
        check({tag, "_holdoff_cleared"}, holdoff_o, 0);
        fin = 1'b1;
      end
      start_i = fin ? 1'b0 : 1'($urandom);
      prev_armed = armed_o;
      @(posedge clk);
      edge_n++;
    end
    start_i = 1'b0;
    check({tag, "_finished_in_bound"}, fin, 1);
    check({tag, "_attempts"}, n_att, exp_n);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_tgt_low_cycles"}, tgt_lo, exp_tgt);
  endtask

  function automatic vec_t rand_vec();
    vec_t   v;
    longint t;
    v.hs  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 6) : $urandom_range(0, 40);
    t     = longint'(v.hs) + $urandom_range(0, 4);
    v.he  = (t > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(t);
    if ($urandom_range(0, 4) == 0 && v.hs != 0) v.he = v.hs - 1;
    v.ps  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 6) : $urandom_range(0, 40);
    t     = longint'(v.ps) + $urandom_range(0, 4);
    v.pe  = (t > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(t);
    if ($urandom_range(0, 4) == 0 && v.ps != 0) v.pe = v.ps - 1;
    v.hst = 16'($urandom_range(0, 3));
    v.pst = 8'($urandom_range(0, 3));
    v.rep = 8'($urandom_range(0, 3));
    v.cd  = 24'($urandom_range(0, 6));
    v.tmo = 24'($urandom_range(0, 12));
    v.rdy = $urandom_range(0, 12);
    if (v.tmo == 0 && v.rdy == 0) v.rdy = 3;
    v.exp_att = -1;
    v.exp_to  = (v.tmo != 0) && (v.rdy == 0 || int'(v.tmo) < v.rdy);
    return v;
  endfunction

  initial begin
    vec_t tbl[12];
    vec_t v;
    int   cnt, bad;

    //            hs            he            hst     ps            pe            pst    rep cd   tmo  rdy att to
    tbl[0]  = '{32'd10,       32'd12,       16'd1,  32'd4,        32'd8,        8'd2,  1, 2,   0,   3, 9, 1'b0};
    tbl[1]  = '{32'd5,        32'd5,        16'd0,  32'd7,        32'd7,        8'd1,  0, 5,   0,   2, 1, 1'b0};
    tbl[2]  = '{32'd5,        32'd5,        16'd0,  32'd7,        32'd7,        8'd1,  3, 5,   0,   2, 3, 1'b0};
    tbl[3]  = '{32'd0,        32'd0,        16'd1,  32'd1,        32'd1,        8'd0,  2, 0,   0,   1, 2, 1'b0};
    tbl[4]  = '{32'd0,        32'd0,        16'd0,  32'd0,        32'd0,        8'd0,  1, 1,   20,  0, 1, 1'b1};
    tbl[5]  = '{32'd0,        32'd0,        16'd0,  32'd0,        32'd0,        8'd0,  1, 1,   6,   6, 1, 1'b0};
    tbl[6]  = '{32'd0,        32'd0,        16'd1,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 8'd8, 1, 1,   0,   2, 1, 1'b0};
    tbl[7]  = '{32'd20,       32'd10,       16'd1,  32'd9,        32'd3,        8'd2,  1, 1,   0,   2, 1, 1'b0};
    tbl[8]  = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 16'h10, 32'd1,      32'd3,        8'd1,  1, 3,   0,   1, 3, 1'b0};
    tbl[9]  = '{32'd7,        32'd7,        16'd0,  32'hFFFF_FF00, 32'hFFFF_FFFF, 8'hFF, 1, 4,  0,   2, 2, 1'b0};
    tbl[10] = '{32'd1,        32'd3,        16'd2,  32'd0,        32'd0,        8'd0,  2, 4,   4,   9, 4, 1'b1};
    tbl[11] = '{32'd100,      32'd102,      16'd1,  32'd0,        32'd0,        8'd0,  1, 10,  0,   2, 3, 1'b0};

    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    drive_cfg(tbl[0]);
    repeat (3) @(posedge clk);
    #1;
    check("rst_armed", armed_o, 0);
    check("rst_holdoff", holdoff_o, 0);
    check("rst_pulse", pulse_o, 0);
    check("rst_tgt_rst_n", tgt_rst_n_o, 1);
    check("rst_att_valid", att_valid_o, 0);
    check("rst_att_timeout", att_timeout_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_sweep(tbl[i], $sformatf("t%0d", i));

    // Abort while waiting for rdy that never comes.
    v = tbl[4];
    v.tmo = 24'd0;
    @(negedge clk);
    drive_cfg(v);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    cnt = 0;
    while (!armed_o && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("abort_armed_before", armed_o, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    check("abort_armed_next", armed_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_att_valid", att_valid_o, 0);
    check("abort_tgt_rst_n", tgt_rst_n_o, 1);
    @(negedge clk);
    abort_i = 1'b0;
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done_o || att_valid_o || busy_o) bad++;
    end
    check("abort_quiet_after", bad, 0);

    // Reset asserted part-way through a cooldown, then a fresh sweep.
    @(negedge clk);
    drive_cfg(tbl[11]);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    cnt = 0;
    while (!att_valid_o && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("rstmid_first_att", att_valid_o, 1);
    check("rstmid_holdoff_before", holdoff_o, 100);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_holdoff", holdoff_o, 0);
    check("rstmid_busy", busy_o, 0);
    check("rstmid_armed", armed_o, 0);
    check("rstmid_tgt_rst_n", tgt_rst_n_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(tbl[11], "restart");

    for (int k = 0; k < 8; k++) begin
      v = rand_vec();
      run_sweep(v, $sformatf("r%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
